cat_score_mac: RTL and testbench



---
 rtl/cat_score_mac_pkg.sv | 16 +
 rtl/cat_mac_pipe.sv | 54 +++++
 rtl/cat_score_mac.sv | 141 ++++++++++++++
 tb/tb_cat_score_mac.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cat_score_mac_pkg.sv
// Shared types and default widths for the cat score MAC and the register files it reads.
package cat_score_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINISH
    } state_e;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_ADDR_DEPTH = 12;
    localparam int PROD_WIDTH     = 2 * DEF_DATA_WIDTH;
    localparam int CNT_WIDTH      = DEF_ADDR_DEPTH + 1;

endpackage

// File: rtl/cat_mac_pipe.sv
// Signed multiply stage followed by an accumulator; clear empties the accumulator for a new run.
module cat_mac_pipe
    import cat_score_mac_pkg::*;
#(
    parameter int PROD_W    = PROD_WIDTH,
    parameter int ACC_WIDTH = PROD_WIDTH + DEF_ADDR_DEPTH + 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        rd_valid,
    input  logic signed [PROD_W/2-1:0]  pixel_data,
    input  logic signed [PROD_W/2-1:0]  weight_data,
    output logic signed [ACC_WIDTH-1:0] acc
);

    logic signed [PROD_W-1:0]    prod_p1_q, prod_p1_d;
    logic                        vld_p1_q, vld_p1_d;
    logic signed [ACC_WIDTH-1:0] acc_p2_q, acc_p2_d;

    always_comb begin
        prod_p1_d = prod_p1_q;
        vld_p1_d  = rd_valid;
        acc_p2_d  = acc_p2_q;
        // Read data is only meaningful in the rd_valid cycle; hold otherwise.
        if (rd_valid) begin
            prod_p1_d = pixel_data * weight_data;
        end
        if (clear) begin
            acc_p2_d = '0;
        end else if (vld_p1_q) begin
            acc_p2_d = acc_p2_q + ACC_WIDTH'(prod_p1_q);
        end
    end

    // Stage p1: product register (data only, no reset)
    always_ff @(posedge clock) begin
        prod_p1_q <= prod_p1_d;
    end

    // Stage p2: accumulator and valid tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            acc_p2_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            acc_p2_q <= acc_p2_d;
        end
    end

    assign acc = acc_p2_q;

endmodule

// File: rtl/cat_score_mac.sv
// Streams pixel/weight pairs out of the register files, accumulates signed products,
// adds a bias and reports the score with an is_cat decision and a done pulse.
module cat_score_mac
    import cat_score_mac_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_DEPTH   = DEF_ADDR_DEPTH,
    parameter int NUM_ELEMENTS = 2 ** ADDR_DEPTH,
    parameter int ACC_WIDTH    = 2 * DATA_WIDTH + ADDR_DEPTH + 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [ACC_WIDTH-1:0] bias,
    output logic [ADDR_DEPTH-1:0]       mem_address,
    output logic                        mem_en_read,
    input  logic signed [DATA_WIDTH-1:0] pixel_data,
    input  logic signed [DATA_WIDTH-1:0] weight_data,
    output logic                        busy,
    output logic                        done,
    output logic signed [ACC_WIDTH-1:0] score,
    output logic                        is_cat
);

    // Counter width follows the package default, rescaled to this instance's depth.
    localparam int CNT_W = CNT_WIDTH - DEF_ADDR_DEPTH + ADDR_DEPTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ELEMENTS);

    function automatic logic is_positive(input logic signed [ACC_WIDTH-1:0] v);
        return !v[ACC_WIDTH-1] && (v != '0);
    endfunction

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [ADDR_DEPTH-1:0]       addr_q, addr_d;
    logic                        en_q, en_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic signed [ACC_WIDTH-1:0] score_q, score_d;
    logic                        is_cat_q, is_cat_d;
    logic                        clear;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;

    cat_mac_pipe #(
        .PROD_W    (2 * DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_pipe (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .rd_valid    (rd_valid_q),
        .pixel_data  (pixel_data),
        .weight_data (weight_data),
        .acc         (acc)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        en_d       = en_q;
        rd_valid_d = en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        score_d    = score_q;
        is_cat_d   = is_cat_q;
        clear      = 1'b0;
        sum        = acc + bias;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    count_d = CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // count_q holds the next address to issue, outputs being registered.
                if (count_q == LAST_CNT) begin
                    state_d = ST_DRAIN;
                    en_d    = 1'b0;
                    addr_d  = '0;
                end else begin
                    addr_d  = count_q[ADDR_DEPTH-1:0];
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // The last accumulate lands on the same edge that enters FINISH.
                if (!rd_valid_q) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                score_d  = sum;
                is_cat_d = is_positive(sum);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            en_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            score_q    <= '0;
            is_cat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            score_q    <= score_d;
            is_cat_q   <= is_cat_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_en_read = en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign score       = score_q;
    assign is_cat      = is_cat_q;

endmodule

// File: tb/tb_cat_score_mac.sv
// Bench for cat_score_mac: register-file models, a run-level reference model and directed plus random runs.
module tb_cat_score_mac;

    localparam int DW = 24;
    localparam int AD = 3;
    localparam int NE = 8;
    localparam int AW = 2 * DW + AD + 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic signed [AW-1:0] bias  = '0;
    logic [AD-1:0]        mem_address;
    logic                 mem_en_read;
    logic signed [DW-1:0] pixel_data;
    logic signed [DW-1:0] weight_data;
    logic                 busy;
    logic                 done;
    logic signed [AW-1:0] score;
    logic                 is_cat;

    logic signed [DW-1:0] pix_mem [NE];
    logic signed [DW-1:0] wt_mem  [NE];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: run timing by cycle count, result by plain arithmetic.
    bit     m_run   = 1'b0;
    bit     m_done  = 1'b0;
    bit     m_cat   = 1'b0;
    int     m_t     = 0;
    longint m_sum   = 0;
    longint m_score = 0;

    always #5 clock = ~clock;

    cat_score_mac #(
        .DATA_WIDTH   (DW),
        .ADDR_DEPTH   (AD),
        .NUM_ELEMENTS (NE),
        .ACC_WIDTH    (AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bias        (bias),
        .mem_address (mem_address),
        .mem_en_read (mem_en_read),
        .pixel_data  (pixel_data),
        .weight_data (weight_data),
        .busy        (busy),
        .done        (done),
        .score       (score),
        .is_cat      (is_cat)
    );

    // Register files: one-edge read latency, junk on the bus when not reading.
    always @(posedge clock) begin
        pixel_data  <= mem_en_read ? pix_mem[mem_address] : DW'($urandom);
        weight_data <= mem_en_read ? wt_mem[mem_address]  : DW'($urandom);
    end

    always @(posedge clock) begin
        if (reset) begin
            m_run   = 1'b0;
            m_done  = 1'b0;
            m_cat   = 1'b0;
            m_t     = 0;
            m_score = 0;
        end else begin
            m_done = 1'b0;
            if (m_run) begin
                m_t++;
                if (m_t == NE + 3) begin
                    m_run   = 1'b0;
                    m_score = m_sum + longint'(bias);
                    m_cat   = (m_score > 0);
                    m_done  = 1'b1;
                end
            end else if (start) begin
                m_run = 1'b1;
                m_t   = 0;
                m_sum = 0;
                for (int i = 0; i < NE; i++)
                    m_sum += longint'(pix_mem[i]) * longint'(wt_mem[i]);
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy",     longint'(busy),        longint'(m_run));
            check("done",     longint'(done),        longint'(m_done));
            check("en_read",  longint'(mem_en_read), longint'(m_run && m_t < NE));
            check("address",  longint'(mem_address), (m_run && m_t < NE) ? longint'(m_t) : 0);
            check("score",    longint'(score),       m_score);
            check("is_cat",   longint'(is_cat),      longint'(m_cat));
        end
    end

    task automatic run_once(input longint b, output int bcycles, output int dones);
        bias    = AW'(b);
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        bcycles = 0;
        dones   = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcycles++;
            if (done) begin
                dones++;
                break;
            end
            @(negedge clock);
        end
        if (dones == 0) check("run_timeout", 0, 1);
        @(negedge clock);
    endtask

    task automatic load_scn1();
        for (int i = 0; i < NE; i++) begin
            pix_mem[i] = DW'(1);
            wt_mem[i]  = DW'(i + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bc;
        int dn;
        longint b;
        load_scn1();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy",    longint'(busy),        0);
        check("rst_done",    longint'(done),        0);
        check("rst_en_read", longint'(mem_en_read), 0);
        check("rst_score",   longint'(score),       0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);

        // Scenario 1: 1*1 + ... + 1*8 = 36
        run_once(0, bc, dn);
        check("s1_score",  longint'(score),  36);
        check("s1_is_cat", longint'(is_cat), 1);
        check("s1_busy_cycles", bc, NE + 3);

        // Scenario 2: 8 * (2 * -3) + 10 = -38
        for (int i = 0; i < NE; i++) begin
            pix_mem[i] = DW'(2);
            wt_mem[i]  = -DW'(3);
        end
        run_once(10, bc, dn);
        check("s2_score",  longint'(score),  -38);
        check("s2_is_cat", longint'(is_cat), 0);

        // Scenario 3: 8 * 2^46 = 2^49
        for (int i = 0; i < NE; i++) begin
            pix_mem[i] = 24'sh800000;
            wt_mem[i]  = 24'sh800000;
        end
        run_once(0, bc, dn);
        check("s3_score",  longint'(score),  longint'(1) << 49);
        check("s3_is_cat", longint'(is_cat), 1);

        // Scenario 4: strict threshold at zero
        load_scn1();
        run_once(-36, bc, dn);
        check("s4_score",  longint'(score),  0);
        check("s4_is_cat", longint'(is_cat), 0);

        // Scenario 5: start held, then re-pulsed while busy
        bias  = '0;
        start = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) dn++;
            @(negedge clock);
        end
        check("s5_done_count", dn, 1);
        check("s5_score", longint'(score), 36);

        // Scenario 5b: start held across done restarts at the first idle edge
        start = 1'b1;
        dn = 0;
        for (int i = 0; i < 40 && dn == 0; i++) begin
            @(negedge clock);
            if (done) dn++;
        end
        check("s5b_first_done", dn, 1);
        @(negedge clock);
        start = 1'b0;
        check("s5b_restart_busy", longint'(busy), 1);
        dn = 0;
        for (int i = 0; i < 40 && dn == 0; i++) begin
            @(negedge clock);
            if (done) dn++;
        end
        check("s5b_second_done", dn, 1);
        @(negedge clock);

        // Scenario 6: reset during the fourth RUN cycle aborts the run
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("s6_en_read", longint'(mem_en_read), 0);
        check("s6_busy",    longint'(busy),        0);
        check("s6_score",   longint'(score),       0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dn++;
            @(negedge clock);
        end
        check("s6_no_done", dn, 0);
        run_once(0, bc, dn);
        check("s6_rerun_score", longint'(score), 36);

        // Random runs against the reference model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NE; i++) begin
                pix_mem[i] = DW'($urandom);
                wt_mem[i]  = DW'($urandom);
            end
            b = (longint'($urandom) << 17) - (longint'(1) << 48);
            if (r == 0) b = -m_sum;
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_once(b, bc, dn);
            check("rnd_busy_cycles", bc, NE + 3);
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
